// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / reset consumers.
// The master side is the sequencer; the slave side is the PLL plus downstream logic.
interface pll_reset_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             locked;
   logic             pll_rst;
   logic             core_rst;
   logic             io_rst;
   logic             ready;
   logic [CNT_W-1:0] timeout_cnt;
   logic [CNT_W-1:0] lock_loss_cnt;

   modport master (
      input  locked,
      output pll_rst, core_rst, io_rst, ready, timeout_cnt, lock_loss_cnt
   );

   modport slave (
      output locked,
      input  pll_rst, core_rst, io_rst, ready, timeout_cnt, lock_loss_cnt
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Reference-clock sequencer: restarts the PLL, waits for a stable lock, then releases
// core reset and, IO_DELAY cycles later, io reset. Counts timeouts and lock losses.
module pll_reset_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 100000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int IO_DELAY       = 8,
   parameter int CNT_W          = 8
) (
   input  logic                 refclk,
   input  logic                 rst,
   pll_reset_sequencer_if.master bus
);

   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B   = (STABLE_CYCLES > IO_DELAY) ? STABLE_CYCLES : IO_DELAY;
   localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(MAX_CNT) + 1;

   typedef logic [CW-1:0]    cnt_t;
   typedef logic [CNT_W-1:0] evt_t;

   localparam cnt_t PLL_RST_LAST = cnt_t'(PLL_RST_CYCLES - 1);
   localparam cnt_t LOCK_LAST    = cnt_t'(LOCK_TIMEOUT - 1);
   localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYCLES - 1);
   localparam cnt_t IO_LAST      = cnt_t'(IO_DELAY - 1);

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t                 state_q, state_d;
   cnt_t                   cnt_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_s;
   logic                   timeout_hit;
   logic                   loss_hit;

   logic pll_rst_q, core_rst_q, io_rst_q, ready_q;
   evt_t timeout_cnt_q, lock_loss_cnt_q;

   // locked is asynchronous to refclk; only sync_q[last] is used by the FSM.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge refclk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked};
   end

   assign locked_s = sync_q[SYNC_STAGES-1];

   // NOTE: every signal driven here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      loss_hit    = 1'b0;
      case (state_q)
         S_PLL_RST: begin
            if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = S_STABLE;
            end else if (cnt_q == LOCK_LAST) begin
               state_d     = S_PLL_RST;
               timeout_hit = 1'b1;
            end
         end
         S_STABLE: begin
            // Short dropouts here go back to waiting without restarting the PLL.
            if (!locked_s) begin
               state_d  = S_WAIT_LOCK;
               loss_hit = 1'b1;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!locked_s) begin
               state_d  = S_PLL_RST;
               loss_hit = 1'b1;
            end else if (cnt_q == IO_LAST) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               state_d  = S_PLL_RST;
               loss_hit = 1'b1;
            end
         end
         default: state_d = S_PLL_RST;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q         <= S_PLL_RST;
         cnt_q           <= '0;
         pll_rst_q       <= 1'b1;
         core_rst_q      <= 1'b1;
         io_rst_q        <= 1'b1;
         ready_q         <= 1'b0;
         timeout_cnt_q   <= '0;
         lock_loss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= (state_d != state_q) ? '0 : cnt_q + cnt_t'(1);
         pll_rst_q  <= (state_d == S_PLL_RST);
         core_rst_q <= (state_d == S_PLL_RST) || (state_d == S_WAIT_LOCK) ||
                       (state_d == S_STABLE);
         io_rst_q   <= (state_d != S_RUN);
         ready_q    <= (state_d == S_RUN);
         if (timeout_hit && (timeout_cnt_q != '1))
            timeout_cnt_q <= timeout_cnt_q + evt_t'(1);
         if (loss_hit && (lock_loss_cnt_q != '1))
            lock_loss_cnt_q <= lock_loss_cnt_q + evt_t'(1);
      end
   end

   assign bus.pll_rst       = pll_rst_q;
   assign bus.core_rst      = core_rst_q;
   assign bus.io_rst        = io_rst_q;
   assign bus.ready         = ready_q;
   assign bus.timeout_cnt   = timeout_cnt_q;
   assign bus.lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock activity,
// every cycle compared against a phase/age reference model.
module tb_pll_reset_sequencer;

   localparam int SYNC_STAGES    = 2;
   localparam int PLL_RST_CYCLES = 4;
   localparam int LOCK_TIMEOUT   = 20;
   localparam int STABLE_CYCLES  = 8;
   localparam int IO_DELAY       = 3;
   localparam int CNT_W          = 8;
   localparam int CNT_MAX        = (1 << CNT_W) - 1;

   localparam int PH_PLL    = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_REL    = 3;
   localparam int PH_RUN    = 4;

   logic refclk = 1'b0;
   logic rst;

   pll_reset_sequencer_if #(.CNT_W(CNT_W)) bus ();

   pll_reset_sequencer #(
      .SYNC_STAGES   (SYNC_STAGES),
      .PLL_RST_CYCLES(PLL_RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .IO_DELAY      (IO_DELAY),
      .CNT_W         (CNT_W)
   ) dut (
      .refclk(refclk),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 refclk = ~refclk;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   // Reference model: the sequence is a ladder of phases, each with a dwell time.
   int m_phase = PH_PLL;
   int m_age   = 0;
   int m_tc    = 0;
   int m_lc    = 0;
   bit m_sync [SYNC_STAGES];
   int dwell [4] = '{PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, IO_DELAY};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit l);
      bit ls;
      int nxt;
      bit expired;
      if (r) begin
         m_phase = PH_PLL;
         m_age   = 0;
         m_tc    = 0;
         m_lc    = 0;
         for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 1'b0;
         return;
      end
      ls      = m_sync[SYNC_STAGES-1];
      nxt     = m_phase;
      expired = (m_phase < PH_RUN) && (m_age + 1 == dwell[m_phase]);
      if (m_phase == PH_WAIT) begin
         if (ls) nxt = PH_STABLE;
         else if (expired) begin
            nxt  = PH_PLL;
            m_tc = (m_tc < CNT_MAX) ? m_tc + 1 : m_tc;
         end
      end else if (m_phase >= PH_STABLE && !ls) begin
         nxt  = (m_phase == PH_STABLE) ? PH_WAIT : PH_PLL;
         m_lc = (m_lc < CNT_MAX) ? m_lc + 1 : m_lc;
      end else if (expired) begin
         nxt = m_phase + 1;
      end
      m_age   = (nxt != m_phase) ? 0 : m_age + 1;
      m_phase = nxt;
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = l;
   endtask

   task automatic check_all();
      string t;
      t = $sformatf("cyc%0d", ncyc);
      chk({t, " pll_rst"},       bus.pll_rst,       32'(m_phase == PH_PLL));
      chk({t, " core_rst"},      bus.core_rst,      32'(m_phase < PH_REL));
      chk({t, " io_rst"},        bus.io_rst,        32'(m_phase < PH_RUN));
      chk({t, " ready"},         bus.ready,         32'(m_phase == PH_RUN));
      chk({t, " timeout_cnt"},   bus.timeout_cnt,   32'(m_tc));
      chk({t, " lock_loss_cnt"}, bus.lock_loss_cnt, 32'(m_lc));
   endtask

   // Called at a falling edge: drive inputs, take one rising edge, check at the next fall.
   task automatic cycle(input bit r, input bit l);
      rst        = r;
      bus.locked = l;
      @(posedge refclk);
      model_step(r, l);
      @(negedge refclk);
      ncyc++;
      check_all();
   endtask

   function automatic logic pick(input int which);
      case (which)
         0:       return bus.pll_rst;
         1:       return bus.core_rst;
         2:       return bus.io_rst;
         default: return bus.ready;
      endcase
   endfunction

   // Counts edges until the chosen output reaches val; stops at limit edges.
   task automatic run_until(input int which, input logic val, input bit l,
                            input int limit, output int n);
      n = 0;
      do begin
         cycle(1'b0, l);
         n++;
      end while (pick(which) !== val && n < limit);
   endtask

   initial begin
      int n;
      int a;
      int guard;
      bit l;
      rst        = 1'b1;
      bus.locked = 1'b0;
      @(negedge refclk);

      // Reset
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      chk("reset pll_rst", bus.pll_rst, 1);
      chk("reset core_rst", bus.core_rst, 1);
      chk("reset io_rst", bus.io_rst, 1);
      chk("reset ready", bus.ready, 0);
      chk("reset timeout_cnt", bus.timeout_cnt, 0);
      chk("reset lock_loss_cnt", bus.lock_loss_cnt, 0);
      run_until(0, 1'b0, 1'b0, 50, n);
      chk("pll_rst hold after reset", n, PLL_RST_CYCLES);

      // Timeouts: lock never arrives
      for (int k = 1; k <= 3; k++) begin
         run_until(0, 1'b1, 1'b0, 100, n);
         chk($sformatf("timeout %0d wait", k), n, LOCK_TIMEOUT);
         chk($sformatf("timeout %0d timeout_cnt", k), bus.timeout_cnt, k);
         run_until(0, 1'b0, 1'b0, 50, n);
         chk($sformatf("timeout %0d pll_rst pulse", k), n, PLL_RST_CYCLES);
      end

      // Glitch in STABLE
      repeat ($urandom_range(0, 10)) cycle(1'b0, 1'b0);
      a     = $urandom_range(0, 3);
      guard = 0;
      do begin
         cycle(1'b0, 1'b1);
         guard++;
      end while (!(m_phase == PH_STABLE && m_age == a) && guard < 50);
      chk("reached STABLE", guard < 50, 1);
      repeat (3) begin
         cycle(1'b0, 1'b0);
         chk("glitch pll_rst low", bus.pll_rst, 0);
      end
      chk("glitch lock_loss_cnt", bus.lock_loss_cnt, 1);
      run_until(1, 1'b0, 1'b1, 100, n);
      chk("relock to core release", n, SYNC_STAGES + 1 + STABLE_CYCLES);
      run_until(2, 1'b0, 1'b1, 50, n);
      chk("core to io release", n, IO_DELAY);
      chk("ready with io release", bus.ready, 1);

      // Loss in RUN, then the whole sequence again
      repeat ($urandom_range(5, 20)) cycle(1'b0, 1'b1);
      run_until(0, 1'b1, 1'b0, 20, n);
      chk("loss to pll_rst", n, SYNC_STAGES + 1);
      chk("loss core_rst", bus.core_rst, 1);
      chk("loss io_rst", bus.io_rst, 1);
      chk("loss ready", bus.ready, 0);
      chk("loss lock_loss_cnt", bus.lock_loss_cnt, 2);
      run_until(0, 1'b0, 1'b0, 50, n);
      chk("restart pll_rst pulse", n, PLL_RST_CYCLES);
      repeat ($urandom_range(0, 12)) cycle(1'b0, 1'b0);
      run_until(1, 1'b0, 1'b1, 100, n);
      chk("clean lock to core release", n, SYNC_STAGES + 1 + STABLE_CYCLES);
      run_until(2, 1'b0, 1'b1, 50, n);
      chk("clean core to io release", n, IO_DELAY);
      chk("clean ready", bus.ready, 1);

      // Random lock activity with occasional reset
      for (int i = 0; i < 60; i++) begin
         l = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) cycle(1'b1, l);
         repeat ($urandom_range(1, l ? 40 : 30)) cycle(1'b0, l);
      end

      // Saturation of timeout_cnt
      cycle(1'b1, 1'b0);
      repeat (300 * (PLL_RST_CYCLES + LOCK_TIMEOUT) + 10) cycle(1'b0, 1'b0);
      chk("timeout_cnt saturated", bus.timeout_cnt, CNT_MAX);

      // Reset during RELEASE
      guard = 0;
      do begin
         cycle(1'b0, 1'b1);
         guard++;
      end while (m_phase != PH_REL && guard < 200);
      chk("reached RELEASE", guard < 200, 1);
      chk("in RELEASE core_rst", bus.core_rst, 0);
      cycle(1'b1, 1'b1);
      chk("rst in RELEASE pll_rst", bus.pll_rst, 1);
      chk("rst in RELEASE core_rst", bus.core_rst, 1);
      chk("rst in RELEASE timeout_cnt", bus.timeout_cnt, 0);
      chk("rst in RELEASE lock_loss_cnt", bus.lock_loss_cnt, 0);
      run_until(3, 1'b1, 1'b1, 100, n);
      chk("ready after rst recovery", bus.ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", ncyc);
      $fatal(1, "watchdog");
   end

endmodule
